// File: rtl/muxn_seq.sv
// muxn_seq: registered N-input selector for real-valued matrix elements.
//
// Two operating modes, chosen while idle:
//   direct (mode=0) - registered N:1 mux, out follows in[sel] one clock later.
//   scan   (mode=1) - a start pulse snapshots every input, then the snapshot
//                     is streamed out one element per accepted valid/ready beat.
//
// Build option:
//   MUXN_SEQ_SKIP_ZERO_EN - when defined, scan mode drops snapshot entries equal
//                           to 0.0 and out_idx reports each emitted entry's true
//                           position. When undefined, every entry is emitted.
//                           Direct mode is the same in both builds.

module muxn_seq #(
  parameter int NUM_IN = 16,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic             clk,
  input  logic             rst,
  input  real              in [NUM_IN],
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  input  logic             start,
  input  logic             out_ready,
  output real              out,
  output logic             out_valid,
  output logic [SEL_W-1:0] out_idx,
  output logic             busy,
  output logic             done
);

  // Controller states.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  // Input count as an SEL_W+1 bit value, so an out-of-range select can be
  // detected without mixing widths (NUM_IN never exceeds 2**SEL_W).
  localparam logic [SEL_W:0] NUM_IN_W = NUM_IN[SEL_W:0];

  logic [1:0]       state_reg;
  real              snap_reg [NUM_IN];
  real              out_reg;
  logic             out_valid_reg;
  logic [SEL_W-1:0] out_idx_reg;

  // Per-entry "eligible for emission" flags, for the live inputs (used at
  // start) and for the frozen snapshot (used after each transfer).
  logic [NUM_IN-1:0] in_nz;
  logic [NUM_IN-1:0] snap_nz;

  // Search results: first eligible input, and next eligible snapshot entry
  // strictly after the index currently presented.
  logic             first_found;
  logic [SEL_W-1:0] first_idx;
  logic             next_found;
  logic [SEL_W-1:0] next_idx;

  logic             sel_in_range;

  assign sel_in_range = ({1'b0, sel} < NUM_IN_W);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_IN; gi++) begin : g_elig
`ifdef MUXN_SEQ_SKIP_ZERO_EN
      // Sparse compaction: only non-zero entries are emitted.
      assign in_nz[gi]   = (in[gi] != 0.0);
      assign snap_nz[gi] = (snap_reg[gi] != 0.0);
`else
      // Dense scan: every entry is emitted, so every entry is eligible.
      assign in_nz[gi]   = 1'b1;
      assign snap_nz[gi] = 1'b1;
`endif
    end
  endgenerate

  // Priority search for the lowest eligible input index (scan entry point).
  always_comb begin
    first_found = 1'b0;
    first_idx   = '0;
    for (int i = NUM_IN - 1; i >= 0; i--) begin
      if (in_nz[i]) begin
        first_found = 1'b1;
        first_idx   = SEL_W'(i);
      end
    end
  end

  // Priority search for the lowest eligible snapshot index above the current
  // one; no hit means the presented beat is the last of the scan.
  always_comb begin
    next_found = 1'b0;
    next_idx   = '0;
    for (int i = NUM_IN - 1; i >= 0; i--) begin
      if (snap_nz[i] && (i > int'(out_idx_reg))) begin
        next_found = 1'b1;
        next_idx   = SEL_W'(i);
      end
    end
  end

  // Main controller: direct mux, snapshot capture and stream serialisation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      out_reg       <= 0.0;
      out_valid_reg <= 1'b0;
      out_idx_reg   <= '0;
      for (int i = 0; i < NUM_IN; i++) begin
        snap_reg[i] <= 0.0;
      end
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (!mode) begin
            // Direct path; start and out_ready are ignored here.
            out_idx_reg <= sel;
            if (sel_in_range) begin
              out_reg       <= in[sel];
              out_valid_reg <= 1'b1;
            end else begin
              out_reg       <= 0.0;
              out_valid_reg <= 1'b0;
            end
          end else begin
            out_valid_reg <= 1'b0;
            if (start) begin
              // Freeze all inputs; the first beat is taken straight from the
              // live inputs because the snapshot is being written this edge.
              for (int i = 0; i < NUM_IN; i++) begin
                snap_reg[i] <= in[i];
              end
              out_idx_reg   <= first_idx;
              out_reg       <= in[first_idx];
              out_valid_reg <= first_found;
              state_reg     <= ST_SCAN;
            end
          end
        end

        ST_SCAN: begin
          if (!out_valid_reg) begin
            // Nothing eligible in the snapshot: finish with zero beats.
            state_reg <= ST_FIN;
          end else if (out_ready) begin
            if (next_found) begin
              out_idx_reg <= next_idx;
              out_reg     <= snap_reg[next_idx];
            end else begin
              out_valid_reg <= 1'b0;
              state_reg     <= ST_FIN;
            end
          end
          // out_ready low: hold the presented beat unchanged.
        end

        ST_FIN: begin
          // One-cycle completion pulse; start is not looked at here.
          state_reg <= ST_IDLE;
        end

        default: begin
          state_reg     <= ST_IDLE;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign out       = out_reg;
  assign out_valid = out_valid_reg;
  assign out_idx   = out_idx_reg;
  assign busy      = (state_reg == ST_SCAN);
  assign done      = (state_reg == ST_FIN);

endmodule
